// File: rtl/i2c_msg_framer_pkg.sv
// i2c_msg_framer_pkg: shared constants and state encoding for the I2C message framer
package i2c_msg_framer_pkg;
  localparam logic [7:0] SYNC_DEFAULT = 8'h5A;
  localparam logic [7:0] MAX_LEN = 8'd64;
  typedef enum logic [3:0] {
    IDLE,
    WAIT_QUIET,
    HDR_SYNC,
    HDR_CH,
    HDR_LEN,
    RD,
    CAP,
    PAYLOAD,
    CSUM
  } state_t;
endpackage

// File: rtl/i2c_msg_framer_onehot_to_bin.sv
// onehot_to_bin: index of the lowest set bit of a one-hot vector
module onehot_to_bin #(
  parameter int N = 12
) (
  input  logic [N-1:0] onehot,
  output logic [3:0]   bin
);
  always_comb begin
    bin = '0;
    for (int i = N - 1; i >= 0; i--) if (onehot[i]) bin = 4'(i);
  end
endmodule

// File: rtl/i2c_msg_framer.sv
// i2c_msg_framer: drains a completed I2C FIFO message and emits SYNC, CH, LEN, payload, CSUM
module i2c_msg_framer
  import i2c_msg_framer_pkg::*;
#(
  parameter int N = 12,
  parameter int QUIET = 255,
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [N-1:0] have_msg_bus,
  input  logic [7:0]   len,
  input  logic [7:0]   s_dout,
  output logic [N-1:0] s_rdreq_bus,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy
);
  state_t state;
  logic [3:0] ch, ch_idx;
  logic [15:0] qcnt;
  logic [7:0] len_prev, len_eff, l, csum;
  logic [6:0] rem;
  logic [N-1:0] ch_bit;
  logic accept;
  assign accept = tx_valid & tx_ready;
  assign ch_bit = N'(1) << ch;
  assign len_eff = len == 8'd0 ? MAX_LEN : len;
  assign busy = state != IDLE;
  onehot_to_bin #(.N(N)) u_sel (.onehot(have_msg_bus), .bin(ch_idx));
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      s_rdreq_bus <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      ch <= '0;
      qcnt <= '0;
      len_prev <= '0;
      l <= '0;
      csum <= '0;
      rem <= '0;
    end else begin
      len_prev <= len;
      case (state)
        IDLE: if (|have_msg_bus) begin
          state <= WAIT_QUIET;
          ch <= ch_idx;
          qcnt <= '0;
        end
        WAIT_QUIET: begin
          if (!(|have_msg_bus)) state <= IDLE;
          else if (len != len_prev) qcnt <= '0;
          else if (qcnt == 16'(QUIET - 1)) begin
            // length frozen here; later arrivals wait for the next packet
            l <= len_eff;
            rem <= len_eff[6:0];
            csum <= {4'b0, ch} ^ len_eff;
            tx_data <= SYNC;
            tx_valid <= 1'b1;
            state <= HDR_SYNC;
          end else qcnt <= qcnt + 16'd1;
        end
        HDR_SYNC: if (accept) begin
          tx_data <= {4'b0, ch};
          state <= HDR_CH;
        end
        HDR_CH: if (accept) begin
          tx_data <= l;
          state <= HDR_LEN;
        end
        HDR_LEN: if (accept) begin
          tx_valid <= 1'b0;
          s_rdreq_bus <= ch_bit;
          state <= RD;
        end
        RD: begin
          s_rdreq_bus <= '0;
          state <= CAP;
        end
        CAP: begin
          tx_data <= s_dout;
          tx_valid <= 1'b1;
          csum <= csum ^ s_dout;
          rem <= rem - 7'd1;
          state <= PAYLOAD;
        end
        PAYLOAD: if (accept) begin
          if (rem == 7'd0) begin
            tx_data <= csum;
            state <= CSUM;
          end else begin
            tx_valid <= 1'b0;
            s_rdreq_bus <= ch_bit;
            state <= RD;
          end
        end
        CSUM: if (accept) begin
          tx_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
